// File: rtl/timer_sched.sv
// Multi-channel tick-driven timer scheduler: per-channel periodic/one-shot counters
// whose expiries are queued as pending flags and delivered round-robin on a valid/ready port.
module timer_sched #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_cfg_we,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [CNT_W-1:0] i_cfg_period,
  input  logic             i_cfg_oneshot,
  input  logic             i_cfg_en,
  output logic             o_evt_valid,
  output logic [CH_W-1:0]  o_evt_ch,
  input  logic             i_evt_ready,
  output logic [N_CH-1:0]  o_active,
  output logic [N_CH-1:0]  o_overrun,
  output logic             o_dbg_state
);

  // Event port: o_evt_valid/o_evt_ch stay stable while offered; an event transfers on a
  // clock edge where o_evt_valid && i_evt_ready. A config write to the offered channel
  // without ready withdraws the offer.
  typedef enum logic {ST_IDLE = 1'b0, ST_OFFER = 1'b1} arb_state_t;

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] period [N_CH];
  logic [CNT_W-1:0] cnt    [N_CH];
  logic [N_CH-1:0]  oneshot, active, pend, overrun;
  logic [N_CH-1:0]  wr_sel, expire, hs_clr, avail;
  logic [CH_W-1:0]  last, last_nxt, grant, evt_ch_nxt;
  logic             evt_valid_nxt, grant_found, offer_wr;

  always_comb begin
    wr_sel = '0;
    expire = '0;
    hs_clr = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i] = i_cfg_we && (int'(i_cfg_ch) == i);
      expire[i] = i_tick && active[i] && !wr_sel[i] && (cnt[i] == CNT_W'(1));
      hs_clr[i] = (state == ST_OFFER) && i_evt_ready && (int'(o_evt_ch) == i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
      oneshot <= '0;
      active  <= '0;
      pend    <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_sel[i]) begin
          period[i]  <= i_cfg_period;
          cnt[i]     <= i_cfg_period;
          oneshot[i] <= i_cfg_oneshot;
          active[i]  <= i_cfg_en && (i_cfg_period != '0);
          pend[i]    <= 1'b0;
          overrun[i] <= 1'b0;
        end else begin
          if (i_tick && active[i])
            cnt[i] <= expire[i] ? period[i] : cnt[i] - CNT_W'(1);
          // A re-expiry in the same cycle as delivery keeps pend set without overrun.
          if (expire[i]) begin
            pend[i] <= 1'b1;
            if (pend[i] && !hs_clr[i]) overrun[i] <= 1'b1;
            if (oneshot[i]) active[i] <= 1'b0;
          end else if (hs_clr[i]) begin
            pend[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Round-robin scan from last+1; channels being rewritten this cycle are skipped.
  always_comb begin
    avail       = pend & ~wr_sel;
    grant       = last;
    grant_found = 1'b0;
    for (int off = 1; off <= N_CH; off++) begin
      if (!grant_found && avail[(int'(last) + off) % N_CH]) begin
        grant       = CH_W'((int'(last) + off) % N_CH);
        grant_found = 1'b1;
      end
    end
  end

  assign offer_wr = i_cfg_we && (i_cfg_ch == o_evt_ch);

  always_comb begin
    state_nxt     = state;
    evt_valid_nxt = o_evt_valid;
    evt_ch_nxt    = o_evt_ch;
    last_nxt      = last;
    case (state)
      ST_IDLE: begin
        if (grant_found) begin
          state_nxt     = ST_OFFER;
          evt_valid_nxt = 1'b1;
          evt_ch_nxt    = grant;
        end
      end
      ST_OFFER: begin
        if (i_evt_ready) begin
          state_nxt     = ST_IDLE;
          evt_valid_nxt = 1'b0;
          last_nxt      = o_evt_ch;
        end else if (offer_wr) begin
          state_nxt     = ST_IDLE;
          evt_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        evt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_evt_valid <= 1'b0;
      o_evt_ch    <= '0;
      last        <= CH_W'(N_CH - 1);
    end else begin
      state       <= state_nxt;
      o_evt_valid <= evt_valid_nxt;
      o_evt_ch    <= evt_ch_nxt;
      last        <= last_nxt;
    end
  end

  assign o_active    = active;
  assign o_overrun   = overrun;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_timer_sched.sv
// Directed self-checking bench for timer_sched: periodic, one-shot, round-robin,
// overrun, config/tick collisions and asynchronous reset.
module tb_timer_sched;
  localparam int N_CH = 4, CH_W = 2, CNT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_tick, i_cfg_we, i_cfg_oneshot, i_cfg_en, i_evt_ready;
  logic [CH_W-1:0]  i_cfg_ch;
  logic [CNT_W-1:0] i_cfg_period;
  logic             o_evt_valid, o_dbg_state;
  logic [CH_W-1:0]  o_evt_ch;
  logic [N_CH-1:0]  o_active, o_overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  logic [CH_W-1:0] acc_q[$];
  int              acc_t_q[$];

  timer_sched #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_cfg_we(i_cfg_we),
    .i_cfg_ch(i_cfg_ch), .i_cfg_period(i_cfg_period), .i_cfg_oneshot(i_cfg_oneshot),
    .i_cfg_en(i_cfg_en), .o_evt_valid(o_evt_valid), .o_evt_ch(o_evt_ch),
    .i_evt_ready(i_evt_ready), .o_active(o_active), .o_overrun(o_overrun),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and cycle counter
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc_cnt++;

  // Record every accepted event (inputs change at posedge+1, so negedge is stable)
  always @(negedge i_clk)
    if (i_rst_n && o_evt_valid && i_evt_ready) begin
      acc_q.push_back(o_evt_ch);
      acc_t_q.push_back(cyc_cnt);
    end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic cfg(input int ch, input int per, input bit os, input bit en);
    cyc();
    i_cfg_we = 1'b1; i_cfg_ch = ch[CH_W-1:0]; i_cfg_period = per[CNT_W-1:0];
    i_cfg_oneshot = os; i_cfg_en = en;
    cyc();
    i_cfg_we = 1'b0;
  endtask

  task automatic pulse_tick();
    cyc();
    i_tick = 1'b1;
    cyc();
    i_tick = 1'b0;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0; i_tick = 1'b0; i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_period = '0;
    i_cfg_oneshot = 1'b0; i_cfg_en = 1'b0; i_evt_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", o_evt_valid); end
    n_vec++; if (o_evt_ch !== 2'd0) begin n_err++; $display("FAIL rst_ch: got %0d exp 0", o_evt_ch); end
    n_vec++; if (o_active !== 4'b0) begin n_err++; $display("FAIL rst_active: got %b exp 0000", o_active); end
    n_vec++; if (o_overrun !== 4'b0) begin n_err++; $display("FAIL rst_overrun: got %b exp 0000", o_overrun); end
    n_vec++; if (o_dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b exp 0", o_dbg_state); end
  endtask

  task automatic test_periodic();
    i_evt_ready = 1'b1;
    acc_q.delete();
    cfg(0, 3, 1'b0, 1'b1);
    for (int t = 1; t <= 9; t++) begin
      pulse_tick();
      idle(9);
      @(negedge i_clk);
      n_vec++; if (acc_q.size() !== t / 3) begin n_err++; $display("FAIL per_count tick %0d: got %0d exp %0d", t, acc_q.size(), t / 3); end
    end
    foreach (acc_q[j]) begin
      n_vec++; if (acc_q[j] !== 2'd0) begin n_err++; $display("FAIL per_ch[%0d]: got %0d exp 0", j, acc_q[j]); end
    end
    n_vec++; if (o_active[0] !== 1'b1) begin n_err++; $display("FAIL per_active: got %b exp 1", o_active[0]); end
    cfg(0, 0, 1'b0, 1'b0);
    @(negedge i_clk);
    n_vec++; if (o_active[0] !== 1'b0) begin n_err++; $display("FAIL per_stop: got %b exp 0", o_active[0]); end
  endtask

  task automatic test_oneshot();
    i_evt_ready = 1'b1;
    acc_q.delete();
    cfg(1, 2, 1'b1, 1'b1);
    pulse_tick();
    @(negedge i_clk);
    n_vec++; if (o_active[1] !== 1'b1) begin n_err++; $display("FAIL os_active_t1: got %b exp 1", o_active[1]); end
    idle(5);
    n_vec++; if (acc_q.size() !== 0) begin n_err++; $display("FAIL os_early: got %0d events exp 0", acc_q.size()); end
    pulse_tick();
    @(negedge i_clk);
    n_vec++; if (o_active[1] !== 1'b0) begin n_err++; $display("FAIL os_active_t2: got %b exp 0", o_active[1]); end
    idle(5);
    n_vec++; if (acc_q.size() !== 1 || acc_q[0] !== 2'd1) begin n_err++; $display("FAIL os_event: got %0d events exp 1 on ch 1", acc_q.size()); end
    repeat (4) begin pulse_tick(); idle(5); end
    n_vec++; if (acc_q.size() !== 1) begin n_err++; $display("FAIL os_extra: got %0d events exp 1", acc_q.size()); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    i_evt_ready = 1'b1;
    for (int c = 0; c < N_CH; c++) cfg(c, 1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      acc_q.delete();
      acc_t_q.delete();
      pulse_tick();
      idle(14);
      @(negedge i_clk);
      n_vec++;
      if (acc_q.size() !== 4) begin
        n_err++; $display("FAIL rr_count tick %0d: got %0d exp 4", k, acc_q.size());
      end else begin
        for (int j = 0; j < 4; j++) begin
          n_vec++; if (acc_q[j] !== j[CH_W-1:0]) begin n_err++; $display("FAIL rr_order tick %0d slot %0d: got %0d exp %0d", k, j, acc_q[j], j); end
        end
        for (int j = 1; j < 4; j++) begin
          n_vec++; if (acc_t_q[j] - acc_t_q[j-1] !== 2) begin n_err++; $display("FAIL rr_spacing tick %0d slot %0d: got %0d exp 2", k, j, acc_t_q[j] - acc_t_q[j-1]); end
        end
      end
      n_vec++; if (o_overrun !== 4'b0) begin n_err++; $display("FAIL rr_overrun: got %b exp 0000", o_overrun); end
    end
    for (int c = 0; c < N_CH; c++) cfg(c, 0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    apply_reset();
    i_evt_ready = 1'b0;
    cfg(2, 1, 1'b0, 1'b1);
    pulse_tick();
    idle(1);
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd2) begin n_err++; $display("FAIL ov_offer: got v=%b ch=%0d exp v=1 ch=2", o_evt_valid, o_evt_ch); end
    n_vec++; if (o_overrun !== 4'b0000) begin n_err++; $display("FAIL ov_t1: got %b exp 0000", o_overrun); end
    pulse_tick();
    @(negedge i_clk);
    n_vec++; if (o_overrun !== 4'b0100) begin n_err++; $display("FAIL ov_t2: got %b exp 0100", o_overrun); end
    pulse_tick();
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd2) begin n_err++; $display("FAIL ov_hold: got v=%b ch=%0d exp v=1 ch=2", o_evt_valid, o_evt_ch); end
    cyc(); i_evt_ready = 1'b1;
    cyc(); i_evt_ready = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b0) begin n_err++; $display("FAIL ov_accept: got v=%b exp 0", o_evt_valid); end
    n_vec++; if (o_overrun[2] !== 1'b1) begin n_err++; $display("FAIL ov_sticky: got %b exp 1", o_overrun[2]); end
    cfg(2, 1, 1'b0, 1'b1);
    @(negedge i_clk);
    n_vec++; if (o_overrun[2] !== 1'b0) begin n_err++; $display("FAIL ov_clear: got %b exp 0", o_overrun[2]); end
    // handshake and re-expiry on the same edge
    pulse_tick();
    idle(1);
    cyc(); i_evt_ready = 1'b1; i_tick = 1'b1;
    cyc(); i_evt_ready = 1'b0; i_tick = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b0 || o_overrun[2] !== 1'b0) begin n_err++; $display("FAIL ov_hs_expire: got v=%b ovr=%b exp v=0 ovr=0", o_evt_valid, o_overrun[2]); end
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd2) begin n_err++; $display("FAIL ov_reoffer: got v=%b ch=%0d exp v=1 ch=2", o_evt_valid, o_evt_ch); end
    // config write withdraws the offer
    cfg(2, 1, 1'b0, 1'b1);
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b0) begin n_err++; $display("FAIL ov_withdraw: got v=%b exp 0", o_evt_valid); end
    idle(2);
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b0) begin n_err++; $display("FAIL ov_withdraw_hold: got v=%b exp 0", o_evt_valid); end
    cfg(2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_cfg_collisions();
    apply_reset();
    i_evt_ready = 1'b1;
    acc_q.delete();
    cfg(3, 0, 1'b0, 1'b1);
    @(negedge i_clk);
    n_vec++; if (o_active[3] !== 1'b0) begin n_err++; $display("FAIL zero_period_active: got %b exp 0", o_active[3]); end
    repeat (3) begin pulse_tick(); idle(3); end
    n_vec++; if (acc_q.size() !== 0) begin n_err++; $display("FAIL zero_period_events: got %0d exp 0", acc_q.size()); end
    cfg(0, 5, 1'b0, 1'b1);
    repeat (4) begin pulse_tick(); idle(3); end
    cyc();
    i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_period = 16'd5; i_cfg_oneshot = 1'b0; i_cfg_en = 1'b1; i_tick = 1'b1;
    cyc();
    i_cfg_we = 1'b0; i_tick = 1'b0;
    idle(4);
    @(negedge i_clk);
    n_vec++; if (acc_q.size() !== 0) begin n_err++; $display("FAIL wr_tick_collide: got %0d events exp 0", acc_q.size()); end
    for (int t = 1; t <= 5; t++) begin
      pulse_tick();
      idle(3);
      @(negedge i_clk);
      n_vec++; if (acc_q.size() !== ((t == 5) ? 1 : 0)) begin n_err++; $display("FAIL reload_tick %0d: got %0d exp %0d", t, acc_q.size(), (t == 5) ? 1 : 0); end
    end
    n_vec++; if (acc_q.size() !== 1 || acc_q[0] !== 2'd0) begin n_err++; $display("FAIL reload_ch: got %0d events exp 1 on ch 0", acc_q.size()); end
  endtask

  task automatic test_async_reset();
    i_evt_ready = 1'b0;
    cfg(3, 1, 1'b0, 1'b1);
    cfg(1, 1, 1'b0, 1'b1);
    pulse_tick();
    pulse_tick();
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b1 || o_overrun !== 4'b1010) begin n_err++; $display("FAIL ar_pre: got v=%b ovr=%b exp v=1 ovr=1010", o_evt_valid, o_overrun); end
    cyc();
    i_rst_n = 1'b0;
    #2;
    n_vec++; if (o_evt_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b exp 0", o_evt_valid); end
    n_vec++; if (o_active !== 4'b0) begin n_err++; $display("FAIL ar_active: got %b exp 0000", o_active); end
    n_vec++; if (o_overrun !== 4'b0) begin n_err++; $display("FAIL ar_overrun: got %b exp 0000", o_overrun); end
    #1 i_rst_n = 1'b1;
    acc_q.delete();
    cfg(3, 1, 1'b0, 1'b1);
    cfg(1, 1, 1'b0, 1'b1);
    pulse_tick();
    idle(1);
    @(negedge i_clk);
    n_vec++; if (o_evt_valid !== 1'b1 || o_evt_ch !== 2'd1) begin n_err++; $display("FAIL ar_first_grant: got v=%b ch=%0d exp v=1 ch=1", o_evt_valid, o_evt_ch); end
    cyc(); i_evt_ready = 1'b1;
    idle(5);
    @(negedge i_clk);
    n_vec++; if (acc_q.size() !== 2 || acc_q[0] !== 2'd1 || acc_q[1] !== 2'd3) begin n_err++; $display("FAIL ar_order: got %0d events exp ch 1 then ch 3", acc_q.size()); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_round_robin();
    test_overrun();
    test_cfg_collisions();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
